// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - parallel-in serial-out transmit controller, MSB first
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy,
  output logic [7:0]       frame_cnt
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]       r_gap, w_gap_nxt;
  logic [7:0]       r_frame_cnt;
  logic             w_end;
  logic             w_xfer;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_frame_cnt <= '0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      if (w_end)
        r_frame_cnt <= r_frame_cnt + 8'd1;
`ifdef PISO_PARITY_EN
      if (w_xfer)
        r_par <= ^din;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_end       = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    din_ready   = 1'b0;
    case (r_state)
      S_IDLE: din_ready = 1'b1;
      S_SHIFT: begin
        sout       = r_shift[WIDTH-1];
        sout_valid = 1'b1;
        if (r_cnt == '0) begin
`ifdef PISO_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_end = 1'b1;
`endif
        end else begin
          w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        sout       = r_par;
        sout_valid = 1'b1;
        w_end      = 1'b1;
      end
`endif
      S_GAP: begin
        if (r_gap == 4'd0)
          w_state_nxt = S_IDLE;
        else
          w_gap_nxt = r_gap - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // With no gap the last-bit cycle doubles as an accept slot for the next word.
    if (w_end) begin
      if (GAP > 0) begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = GAP_LAST;
      end else begin
        w_state_nxt = S_IDLE;
        din_ready   = 1'b1;
      end
    end

    w_xfer = din_valid && din_ready;
    if (w_xfer) begin
      w_state_nxt = S_SHIFT;
      w_shift_nxt = din;
      w_cnt_nxt   = CNT_LAST;
    end
  end

  assign frame_done = w_end;
  assign busy       = (r_state != S_IDLE);
  assign frame_cnt  = r_frame_cnt;

endmodule
